// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder_pkg : RV32I load/store encodings, FSM state, helpers  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Misaligned or unsupported width code for the given direction.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (f3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = off[0];
                F3_SW:   bad = (off != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = off[0];
                F3_LW:         bad = (off != 2'b00);
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << off;
            F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
            F3_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the right-aligned store data across lanes; byte enables pick the lane.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_SB:   d = {4{wd[7:0]}};
            F3_SH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LW:   r = word;
            F3_LBU:  r = {24'd0, b};
            F3_LHU:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder_if : memory-stage request/response bundle             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] memAdrs;
    logic [31:0] memDataWD;
    logic [31:0] memDataRD;
    logic        ready;
    logic        stall;
    logic        err;

    modport master (
        output req, we, funct3, memAdrs, memDataWD,
        input  memDataRD, ready, stall, err
    );

    modport slave (
        input  req, we, funct3, memAdrs, memDataWD,
        output memDataRD, ready, stall, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array : byte-enabled word array, async read, no reset           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  wire logic              clk,
    input  wire logic [3:0]        be,
    input  wire logic [IDX_W-1:0]  idx,
    input  wire logic [31:0]       wdata,
    output logic      [31:0]       rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[idx][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : fixed-latency RV32I data memory with hazard stall   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_responder_if.slave bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [IDX_W+1:0]  adrs_q, adrs_d;
    logic [31:0]       wd_q, wd_d;
    logic [31:0]       rd_q, rd_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              enter_done;
    logic              acc_we;
    logic [2:0]        acc_f3;
    logic [IDX_W+1:0]  acc_adrs;
    logic [31:0]       acc_wd;
    logic              acc_err;
    logic [3:0]        arr_be;
    logic [31:0]       arr_rdata;
    logic              unused_adrs;

    assign unused_adrs = &{1'b0, bus.memAdrs[31:IDX_W+2]};

    // With zero wait the accept edge is also the DONE edge, so the live
    // request fields must feed the array and load path directly.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we   = bus.we;
            acc_f3   = bus.funct3;
            acc_adrs = bus.memAdrs[IDX_W+1:0];
            acc_wd   = bus.memDataWD;
        end else begin
            acc_we   = we_q;
            acc_f3   = f3_q;
            acc_adrs = adrs_q;
            acc_wd   = wd_q;
        end
    end

    assign acc_err = access_err(acc_we, acc_f3, acc_adrs[1:0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        f3_d       = f3_q;
        adrs_d     = adrs_q;
        wd_d       = wd_q;
        rd_d       = rd_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        enter_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d   = bus.we;
                    f3_d   = bus.funct3;
                    adrs_d = bus.memAdrs[IDX_W+1:0];
                    wd_d   = bus.memDataWD;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (enter_done) begin
            ready_d = 1'b1;
            err_d   = acc_err;
            if (!acc_we) begin
                rd_d = acc_err ? 32'd0 : load_extend(acc_f3, acc_adrs[1:0], arr_rdata);
            end
        end
    end

    // Reset gating keeps an in-flight store from landing while reset is held.
    assign arr_be = (enter_done && acc_we && !acc_err && !reset)
                  ? store_be(acc_f3, acc_adrs[1:0]) : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .be    (arr_be),
        .idx   (acc_adrs[IDX_W+1:2]),
        .wdata (store_data(acc_f3, acc_wd)),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            adrs_q  <= '0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            adrs_q  <= adrs_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign bus.memDataRD = rd_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.stall     = ((state_q == ST_IDLE) && bus.req) || (state_q == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder : random + directed bench, WAIT_CYCLES 0 and 1     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

    logic clk;
    logic rst0, rst1;
    int   n_cmp, n_bad;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0.slave)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: byte-addressed memory image and last load result per instance.
    logic [7:0]  mdl [2][4096];
    logic [31:0] last_rd [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : 1;
    endfunction

    function automatic bit mdl_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a[1:0]);
        if (w) begin
            if (f3 == 3'd0) return 1'b0;
            if (f3 == 3'd1) return (off % 2) != 0;
            if (f3 == 3'd2) return off != 0;
            return 1'b1;
        end
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
        if (f3 == 3'd2) return off != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mdl_load(input int s, input logic [2:0] f3, input logic [31:0] a);
        int          base = int'(a[11:2]) * 4;
        int          hb   = base + (a[1] ? 2 : 0);
        logic [7:0]  b    = mdl[s][base + int'(a[1:0])];
        logic [15:0] h    = {mdl[s][hb+1], mdl[s][hb]};
        logic [31:0] wv   = {mdl[s][base+3], mdl[s][base+2], mdl[s][base+1], mdl[s][base]};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return wv;
            3'd4:    return {24'd0, b};
            default: return {16'd0, h};
        endcase
    endfunction

    task automatic mdl_store(input int s, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        int base = int'(a[11:2]) * 4;
        int n    = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        int lo   = base + ((n == 4) ? 0 : (n == 2) ? (a[1] ? 2 : 0) : int'(a[1:0]));
        for (int k = 0; k < n; k++) mdl[s][lo + k] = wd[8*k +: 8];
    endtask

    task automatic drive(input int s, input bit r, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (s == 0) begin
            bus0.req = r; bus0.we = w; bus0.funct3 = f3; bus0.memAdrs = a; bus0.memDataWD = wd;
        end else begin
            bus1.req = r; bus1.we = w; bus1.funct3 = f3; bus1.memAdrs = a; bus1.memDataWD = wd;
        end
    endtask

    task automatic sample(input int s, output logic [31:0] rd, output logic rdy,
                          output logic st, output logic er);
        if (s == 0) begin
            rd = bus0.memDataRD; rdy = bus0.ready; st = bus0.stall; er = bus0.err;
        end else begin
            rd = bus1.memDataRD; rdy = bus1.ready; st = bus1.stall; er = bus1.err;
        end
    endtask

    task automatic access(input int s, input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd, exp_rd;
        logic        rdy, st, er;
        bit          exp_err, got;
        int          lat;
        exp_err = mdl_err(w, f3, a);
        if (w) begin
            exp_rd = last_rd[s];
            if (!exp_err) mdl_store(s, f3, a, wd);
        end else begin
            exp_rd     = exp_err ? 32'd0 : mdl_load(s, f3, a);
            last_rd[s] = exp_rd;
        end
        @(negedge clk);
        drive(s, 1'b1, w, f3, a, wd);
        #1;
        sample(s, rd, rdy, st, er);
        check_eq("stall_accept", {31'd0, st}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            sample(s, rd, rdy, st, er);
            if (rdy) got = 1'b1;
            else check_eq("stall_busy", {31'd0, st}, 32'd1);
        end
        drive(s, 1'b0, w, f3, a, wd);
        if (!got) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", lat, wait_of(s) + 1);
            check_eq("err", {31'd0, er}, {31'd0, exp_err});
            check_eq(w ? "rd_hold_store" : "rd_load", rd, exp_rd);
            check_eq("stall_done", {31'd0, st}, 32'd0);
            @(posedge clk);
            #1;
            sample(s, rd, rdy, st, er);
            check_eq("ready_pulse", {31'd0, rdy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        rdy, st, er;
        n_cmp = 0;
        n_bad = 0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, rd, rdy, st, er);
            check_eq("reset_rd", rd, 32'd0);
            check_eq("reset_ready", {31'd0, rdy}, 32'd0);
            check_eq("reset_err", {31'd0, er}, 32'd0);
            check_eq("reset_stall", {31'd0, st}, 32'd0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Give the exercised low words a known value.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++)
                access(s, 1'b1, 3'd2, 32'(i * 4), $urandom);

        access(1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        access(1, 1'b0, 3'd2, 32'h10, 32'd0);
        check_eq("lw_deadbeef", bus1.memDataRD, 32'hDEADBEEF);
        access(1, 1'b1, 3'd0, 32'h13, 32'h00000080);
        access(1, 1'b0, 3'd0, 32'h13, 32'd0);
        check_eq("lb_sext", bus1.memDataRD, 32'hFFFFFF80);
        access(1, 1'b0, 3'd4, 32'h13, 32'd0);
        check_eq("lbu_zext", bus1.memDataRD, 32'h00000080);
        access(1, 1'b0, 3'd2, 32'h10, 32'd0);
        check_eq("lw_after_sb", bus1.memDataRD, 32'h80ADBEEF);
        access(1, 1'b0, 3'd1, 32'h11, 32'd0);
        access(1, 1'b0, 3'd2, 32'h10, 32'd0);
        access(1, 1'b0, 3'd3, 32'h10, 32'd0);
        access(0, 1'b1, 3'd2, 32'h1000, 32'h12345678);
        access(0, 1'b0, 3'd2, 32'h0, 32'd0);
        check_eq("wrap_lw", bus0.memDataRD, 32'h12345678);

        for (int n = 0; n < 300; n++) begin
            access(n % 2, 1'($urandom), 3'($urandom), $urandom & 32'hFFFF_F0FF, $urandom);
        end

        // Reset while a store is in flight on the WAIT_CYCLES=1 instance.
        access(1, 1'b0, 3'd2, 32'h24, 32'd0);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 3'd2, 32'h20, 32'hFFFFFFFF);
        @(posedge clk);
        #2;
        rst1 = 1'b1;
        #1;
        sample(1, rd, rdy, st, er);
        check_eq("abort_rd", rd, 32'd0);
        check_eq("abort_ready", {31'd0, rdy}, 32'd0);
        check_eq("abort_err", {31'd0, er}, 32'd0);
        check_eq("abort_stall_req", {31'd0, st}, 32'd1);
        drive(1, 1'b0, 1'b1, 3'd2, 32'h20, 32'hFFFFFFFF);
        #1;
        sample(1, rd, rdy, st, er);
        check_eq("abort_stall_idle", {31'd0, st}, 32'd0);
        last_rd[1] = 32'd0;
        @(negedge clk);
        rst1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            sample(1, rd, rdy, st, er);
            check_eq("abort_no_ready", {31'd0, rdy}, 32'd0);
        end
        access(1, 1'b0, 3'd2, 32'h20, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array; power of two.
REQ-002 Parameter WAIT_CYCLES, default 1: extra access latency in cycles, range 0..15.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req, input, 1: memory-stage access request; held by the requester until ready.
REQ-006 Port we, input, 1: 1 = store, 0 = load.
REQ-007 Port funct3, input, 3: RV32I width and sign code.
REQ-008 Port memAdrs, input, 32: byte address.
REQ-009 Port memDataWD, input, 32: store data, right-aligned.
REQ-010 Port memDataRD, output, 32: registered load data, extended to 32 bits.
REQ-011 Port ready, output, 1: one-cycle pulse marking completion of the accepted request.
REQ-012 Port stall, output, 1: hold request to the hazard unit (drives stall_M and stall of earlier stages).
REQ-013 Port err, output, 1: one-cycle pulse, coincident with ready, for misaligned or illegal access.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-015 IDLE with req=1 SHALL latch we, funct3, memAdrs and memDataWD.
  - On that accept: WAIT_CYCLES>0 -> BUSY with counter = WAIT_CYCLES-1; WAIT_CYCLES=0 -> DONE.
REQ-016 BUSY SHALL decrement the counter each cycle and go to DONE when it is 0.
REQ-017 DONE SHALL assert ready for exactly one cycle, then return to IDLE.
  - req is not accepted in DONE.
REQ-018 Latency: accept at cycle N -> ready at cycle N+WAIT_CYCLES+1.
REQ-019 stall SHALL be combinational: (IDLE & req) | BUSY; it SHALL be 0 in DONE.
REQ-020 Word index SHALL be memAdrs[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (wrap-around).
REQ-021 Loads SHALL decode funct3 as follows; byte lane from addr[1:0], halfword from addr[1]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
REQ-022 Stores SHALL decode funct3 as follows; other bytes unchanged:
  - 000 SB: write memDataWD[7:0] to the addressed lane.
  - 001 SH: write memDataWD[15:0] to the addressed half.
  - 010 SW: write all four lanes.
REQ-023 Store commit SHALL occur on the edge entering DONE, never earlier.
REQ-024 memDataRD SHALL update only on the edge entering DONE for loads, then hold until the next load completion.
  - Stores leave memDataRD unchanged.
REQ-025 An access is in error if any of these holds; such an access SHALL skip the array, complete with normal latency, assert err with ready, and set memDataRD to 0 for loads:
  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Illegal code: load funct3 in {011,110,111}, or store funct3 other than 000/001/010.
REQ-026 A read and a write to the same word in consecutive requests SHALL return the newly written data.

Reset
REQ-027 reset SHALL asynchronously force state IDLE, counter 0, ready 0, err 0, memDataRD 0; stall is then req only.
REQ-028 Reset in BUSY SHALL abort the request; the pending store is not committed.
REQ-029 Array contents SHALL NOT be cleared by reset.

Structure
REQ-030 A shared package SHALL hold the funct3 load/store encodings and the FSM state enum.
REQ-031 The byte-enabled word array SHALL be a sub-module named dmem_array.
  - Ports: clk, 4-bit byte-write enable, word index, write data, read data.
REQ-032 Total RTL SHALL be 120-400 lines.

Verification
REQ-033 WAIT_CYCLES=1: SW 0xDEADBEEF @0x10 at cycle N, then LW @0x10 -> ready at N+2, stall high at N and N+1; LW returns 0xDEADBEEF.
REQ-034 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-035 LH @0x11 -> err=1 with ready, memDataRD=0, word @0x10 unchanged; funct3=011 load -> err=1.
REQ-036 WAIT_CYCLES=0, DEPTH_WORDS=1024: SW 0x12345678 @0x1000 then LW @0x0 -> 0x12345678 (wrap), ready one cycle after each accept.
REQ-037 Reset asserted in BUSY during SW 0xFFFFFFFF @0x20 -> no ready pulse, then LW @0x20 returns the prior value; outputs 0 immediately on reset.
